regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read-port register file with write-through bypass and a per-register
//  scoreboard of pending writes. Next-generation CPU register file: width, depth and read-port
//  count are parameters. Tracks registers whose producer has issued but not yet written back,
//  so the decode stage can stall on RAW hazards. Sits between decode (reads, sb_set) and
//  writeback (we/waddr/wdata).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; depth = 2**ADDR_W; register 0 hardwired to zero
//  NUM_RD    2   number of independent read ports (>=1)
//  TEST_REG  28  register index whose low 16 bits drive test_out
// PORTS
//  clk       in   1                rising-edge clock
//  rst_n     in   1                asynchronous reset, active-low
//  we        in   1                write enable (writeback)
//  waddr     in   ADDR_W           write address
//  wdata     in   DATA_W           write data
//  raddr     in   NUM_RD*ADDR_W    read addresses; port k = raddr[k*ADDR_W +: ADDR_W]
//  rdata     out  NUM_RD*DATA_W    read data; port k = rdata[k*DATA_W +: DATA_W]
//  rd_busy   out  NUM_RD           port k's register has a pending write (RAW hazard)
//  sb_set    in   1                mark sb_addr busy (producer issued)
//  sb_addr   in   ADDR_W           register to mark busy
//  sb_cnt    out  ADDR_W+1         number of registers currently busy
//  test_out  out  16               reg[TEST_REG][15:0]
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers 0, all busy bits 0, sb_cnt 0; rdata 0, rd_busy 0,
//   test_out 0 while held. Reset mid-operation discards pending writes and busy state at once.
//  Write: on posedge with we=1 and waddr!=0, reg[waddr] <= wdata. waddr=0 is ignored.
//  Read: combinational, zero latency. rdata_k = (we && waddr==raddr_k && raddr_k!=0) ? wdata
//   : reg[raddr_k]. raddr_k=0 always returns 0. Bypass applies to every port independently.
//  Scoreboard, per register r (r!=0), next state on posedge:
//   set   = sb_set && sb_addr==r;   clr = we && waddr==r
//   set&clr -> busy 1 (new producer overrides the retiring one); set only -> 1;
//   clr only -> 0; neither -> hold. Register 0 is never busy; sb_set to 0 is ignored.
//   Setting an already-busy register is legal and is not an error.
//  rd_busy_k = busy[raddr_k] && !(we && waddr==raddr_k): a same-cycle writeback resolves the
//   hazard via the bypass. rd_busy_k=0 for raddr_k=0.
//  sb_cnt: registered counter equal to popcount(busy) every cycle; +1 on an idle->busy
//   transition, -1 on busy->idle, unchanged when set and clear coincide on one register or
//   the set/clear on two different registers cancel. Range 0..2**ADDR_W-1; cannot wrap.
//  Write to a non-busy register is legal (plain write, no scoreboard effect).
// TESTING
//  1 rst_n=0 mid-run with busy regs -> rdata 0, rd_busy 0, sb_cnt 0 immediately, no clk needed
//  2 we=1 waddr=5 wdata=32'hDEAD_BEEF; same cycle raddr0=5 -> rdata0=DEAD_BEEF (bypass);
//    next cycle we=0 -> rdata0 still DEAD_BEEF
//  3 we=1 waddr=0 wdata=32'hFFFF_FFFF; raddr0=raddr1=0 -> rdata 0 before and after the edge
//  4 sb_set addr 7 -> next cycle rd_busy0=1 for raddr0=7, sb_cnt=1; we waddr=7 -> rd_busy0=0
//    that cycle, busy cleared next cycle, sb_cnt=0
//  5 sb_set addr 9 and we waddr=9 same cycle on busy reg 9 -> busy stays 1, sb_cnt unchanged
//  6 sb_set 1..31 one per cycle -> sb_cnt reaches 31; then we to 28 with 32'h0000_1234 ->
//    test_out=16'h1234, sb_cnt=30

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a pending-write scoreboard; reads are
// combinational (zero latency), writes and busy bits update on clk; no backpressure, decode stalls on rd_busy.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int TEST_REG = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic [ADDR_W:0]          sb_cnt,
    output logic [15:0]              test_out
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [DEPTH-1:0]  set_vec;
    logic [DEPTH-1:0]  clr_vec;
    logic [ADDR_W:0]   cnt;
    logic              wr_ok;
    logic              set_ok;
    logic              cnt_inc;
    logic              cnt_dec;

    assign wr_ok  = we && (waddr != '0);
    assign set_ok = sb_set && (sb_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // A new producer issued in the same cycle as the old one retires keeps the register busy.
    always_comb begin
        set_vec   = set_ok ? (DEPTH'(1) << sb_addr) : '0;
        clr_vec   = wr_ok  ? (DEPTH'(1) << waddr)   : '0;
        busy_next = (busy & ~clr_vec) | set_vec;
        cnt_inc   = set_ok && !busy[sb_addr];
        cnt_dec   = wr_ok && busy[waddr] && !(set_ok && (sb_addr == waddr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            busy <= busy_next;
            cnt  <= cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
        end
    end

    assign sb_cnt   = cnt;
    assign test_out = regs[TEST_REG][15:0];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;
        assign a   = raddr[k*ADDR_W +: ADDR_W];
        assign hit = we && (waddr == a);
        // Outputs are forced quiet while reset is held, even if a write is presented.
        assign rdata[k*DATA_W +: DATA_W] = (!rst_n || a == '0) ? '0 : (hit ? wdata : regs[a]);
        assign rd_busy[k] = rst_n && (a != '0) && busy[a] && !hit;
    end
endmodule
